// File: rtl/vram_arbiter.sv
// Screen RAM arbiter: video byte-pair fetches take priority over Z80 accesses.
// The CPU is held off with a WAIT-style stall until its single access completes.
module vram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_pix_addr,
  input  logic [ADDR_W-1:0] vid_attr_addr,
  output logic [DATA_W-1:0] vid_pix_data,
  output logic [DATA_W-1:0] vid_attr_data,
  output logic              vid_valid,
  output logic              vid_overrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_V_PIX,
    S_V_ATTR,
    S_V_CAP,
    S_C_WR,
    S_C_RD,
    S_C_CAP
  } state_t;

  state_t r_state, w_next;

  logic [ADDR_W-1:0] r_pix_addr, r_attr_addr, r_addr_hold;
  logic [DATA_W-1:0] r_wdata_hold;
  logic [DATA_W-1:0] r_pix_data, r_attr_data, r_cpu_rdata;
  logic              r_vid_pend, r_armed, r_overrun;
  logic              r_vid_valid, r_cpu_ack;

  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic              w_ram_we;
  logic              w_vid_busy, w_vid_accept, w_cpu_elig;

  assign w_vid_busy = r_vid_pend
                    | (r_state == S_V_PIX)
                    | (r_state == S_V_ATTR)
                    | (r_state == S_V_CAP);
  assign w_vid_accept = vid_req & ~w_vid_busy;
  // Masking with the ack stops a held request from starting a second access.
  assign w_cpu_elig = cpu_req & r_armed & ~r_cpu_ack;

  always_comb begin
    w_next      = r_state;
    w_ram_addr  = r_addr_hold;
    w_ram_wdata = r_wdata_hold;
    w_ram_we    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_vid_pend || vid_req)
          w_next = S_V_PIX;
        else if (w_cpu_elig)
          w_next = cpu_we ? S_C_WR : S_C_RD;
      end
      S_V_PIX: begin
        w_ram_addr = r_pix_addr;
        w_next     = S_V_ATTR;
      end
      S_V_ATTR: begin
        w_ram_addr = r_attr_addr;
        w_next     = S_V_CAP;
      end
      S_V_CAP: w_next = S_IDLE;
      S_C_WR: begin
        w_ram_addr  = cpu_addr;
        w_ram_wdata = cpu_wdata;
        w_ram_we    = 1'b1;
        w_next      = S_IDLE;
      end
      S_C_RD: begin
        w_ram_addr = cpu_addr;
        w_next     = S_C_CAP;
      end
      S_C_CAP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pix_addr   <= '0;
      r_attr_addr  <= '0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
      r_pix_data   <= '0;
      r_attr_data  <= '0;
      r_cpu_rdata  <= '0;
      r_vid_pend   <= 1'b0;
      r_armed      <= 1'b1;
      r_overrun    <= 1'b0;
      r_vid_valid  <= 1'b0;
      r_cpu_ack    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_addr_hold  <= w_ram_addr;
      r_wdata_hold <= w_ram_wdata;
      if (w_vid_accept) begin
        r_pix_addr  <= vid_pix_addr;
        r_attr_addr <= vid_attr_addr;
      end
      if (r_state == S_V_PIX)
        r_vid_pend <= 1'b0;
      if (w_vid_accept)
        r_vid_pend <= 1'b1;
      if (vid_req && w_vid_busy)
        r_overrun <= 1'b1;
      if (!cpu_req)
        r_armed <= 1'b1;
      else if (r_cpu_ack)
        r_armed <= 1'b0;
      if (r_state == S_V_ATTR)
        r_pix_data <= ram_rdata;
      if (r_state == S_V_CAP)
        r_attr_data <= ram_rdata;
      if (r_state == S_C_CAP)
        r_cpu_rdata <= ram_rdata;
      r_vid_valid <= (r_state == S_V_CAP);
      r_cpu_ack   <= (r_state == S_C_WR) || (r_state == S_C_CAP);
    end
  end

  assign vid_pix_data  = r_pix_data;
  assign vid_attr_data = r_attr_data;
  assign vid_valid     = r_vid_valid;
  assign vid_overrun   = r_overrun;
  assign cpu_rdata     = r_cpu_rdata;
  assign cpu_ack       = r_cpu_ack;
  assign cpu_wait      = cpu_req & r_armed & ~r_cpu_ack;
  assign ram_addr      = w_ram_addr;
  assign ram_we        = w_ram_we;
  assign ram_wdata     = w_ram_wdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: synchronous RAM model plus queue-based scoreboard
// of video pairs, CPU completions and RAM writes.
module tb_vram_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_pix_addr = '0;
  logic [AW-1:0] vid_attr_addr = '0;
  logic [DW-1:0] vid_pix_data, vid_attr_data;
  logic          vid_valid, vid_overrun;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack, cpu_wait;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .vid_req      (vid_req),
    .vid_pix_addr (vid_pix_addr),
    .vid_attr_addr(vid_attr_addr),
    .vid_pix_data (vid_pix_data),
    .vid_attr_data(vid_attr_data),
    .vid_valid    (vid_valid),
    .vid_overrun  (vid_overrun),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ack      (cpu_ack),
    .cpu_wait     (cpu_wait),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         t;
    int         lat;
  } ent_t;

  typedef struct {
    logic [AW-1:0] ad;
    logic [7:0]    d;
  } wr_t;

  ent_t vq[$];
  ent_t cq[$];
  wr_t  wq[$];
  ent_t mv, mc;
  wr_t  mw;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int base;
  bit mem_init = 1'b0;

  logic [7:0] mem    [0:8191];
  logic [7:0] shadow [0:8191];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
      mem[13'h0000] <= 8'hA5;
      mem[13'h0001] <= 8'h3C;
      mem[13'h0010] <= 8'h5A;
      mem[13'h1800] <= 8'h47;
      mem_init <= 1'b1;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (vid_valid) begin
        if (vq.size() == 0) chk("vid_unexp", vid_valid, 0);
        else begin
          mv = vq.pop_front();
          chk("vid_pix", vid_pix_data, mv.a);
          chk("vid_attr", vid_attr_data, mv.b);
          chk("vid_lat", cyc - mv.t, mv.lat);
        end
      end
      if (cpu_ack) begin
        ack_cnt <= ack_cnt + 1;
        if (cq.size() == 0) chk("cpu_unexp", cpu_ack, 0);
        else begin
          mc = cq.pop_front();
          if (mc.b[0]) chk("cpu_rdata", cpu_rdata, mc.a);
          chk("cpu_lat_ok", (cyc - mc.t) <= mc.lat, 1);
        end
      end
      if (ram_we) begin
        if (wq.size() == 0) chk("we_unexp", ram_we, 0);
        else begin
          mw = wq.pop_front();
          chk("wr_addr", ram_addr, mw.ad);
          chk("wr_data", ram_wdata, mw.d);
        end
      end
    end
  end

  task automatic push_cpu(input bit we, input logic [AW-1:0] a,
                          input logic [7:0] d, input int maxlat);
    ent_t e;
    wr_t  w;
    e.a   = we ? 8'h00 : shadow[a];
    e.b   = {7'b0, !we};
    e.t   = cyc;
    e.lat = maxlat;
    cq.push_back(e);
    if (we) begin
      shadow[a] = d;
      w.ad = a;
      w.d  = d;
      wq.push_back(w);
    end
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    @(negedge clk);
    while (!cpu_ack && n < 20) begin
      chk("cpu_wait", cpu_wait, 1);
      n++;
      @(negedge clk);
    end
    if (!cpu_ack) chk("cpu_timeout", cpu_ack, 1);
    else chk("cpu_wait_ack", cpu_wait, 0);
  endtask

  task automatic cpu_access(input bit we, input logic [AW-1:0] a,
                            input logic [7:0] d, input int maxlat);
    @(posedge clk); #1;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    push_cpu(we, a, d, maxlat);
    wait_ack();
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic vid_fetch(input logic [AW-1:0] p, input logic [AW-1:0] at,
                           input int dly, input int lat, input bit exp);
    ent_t e;
    repeat (dly) @(posedge clk);
    @(posedge clk); #1;
    vid_req       = 1'b1;
    vid_pix_addr  = p;
    vid_attr_addr = at;
    if (exp) begin
      e.a   = shadow[p];
      e.b   = shadow[at];
      e.t   = cyc;
      e.lat = lat;
      vq.push_back(e);
    end
    @(posedge clk); #1;
    vid_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((vq.size() + cq.size() + wq.size()) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain", vq.size() + cq.size() + wq.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, ram_we, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_wdata"}, ram_wdata, 0);
    chk({tag, "_ack"}, cpu_ack, 0);
    chk({tag, "_rdata"}, cpu_rdata, 0);
    chk({tag, "_wait"}, cpu_wait, 0);
    chk({tag, "_valid"}, vid_valid, 0);
    chk({tag, "_pix"}, vid_pix_data, 0);
    chk({tag, "_attr"}, vid_attr_data, 0);
    chk({tag, "_ovr"}, vid_overrun, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8192; i++) shadow[i] = 8'h00;
    shadow[13'h0000] = 8'hA5;
    shadow[13'h0001] = 8'h3C;
    shadow[13'h0010] = 8'h5A;
    shadow[13'h1800] = 8'h47;

    repeat (3) @(negedge clk);
    chk_zero("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    // basic video fetch
    vid_fetch(13'h0000, 13'h1800, 1, 4, 1'b1);
    drain();

    // write then read back
    cpu_access(1'b1, 13'h1801, 8'h38, 3);
    cpu_access(1'b0, 13'h1801, 8'h00, 4);
    drain();

    // simultaneous video and CPU read: video first
    fork
      vid_fetch(13'h0001, 13'h1801, 0, 4, 1'b1);
      cpu_access(1'b0, 13'h0000, 8'h00, 7);
    join
    drain();

    // video request lands while CPU read is in C_RD
    fork
      cpu_access(1'b0, 13'h1800, 8'h00, 3);
      vid_fetch(13'h0000, 13'h1801, 1, 6, 1'b1);
    join
    drain();

    // held request gets exactly one access until released
    base = ack_cnt;
    @(posedge clk); #1;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 13'h1800;
    push_cpu(1'b0, 13'h1800, 8'h00, 3);
    repeat (20) @(posedge clk);
    #1;
    chk("ack_once", ack_cnt - base, 1);
    chk("wait_held", cpu_wait, 0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    cpu_req = 1'b1;
    push_cpu(1'b0, 13'h1800, 8'h00, 3);
    wait_ack();
    @(posedge clk); #1;
    cpu_req = 1'b0;
    chk("ack_twice", ack_cnt - base, 2);
    drain();

    // overrun from back-to-back strobes
    chk("ovr_before", vid_overrun, 0);
    vid_fetch(13'h0001, 13'h1800, 0, 4, 1'b1);
    vid_fetch(13'h0000, 13'h1801, 0, 0, 1'b0);
    drain();
    chk("ovr_set", vid_overrun, 1);

    // reset in the middle of a CPU write
    base = ack_cnt;
    @(posedge clk); #1;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 13'h0010;
    cpu_wdata = 8'hFF;
    @(posedge clk); #1;
    chk("mid_we", ram_we, 1);
    reset   = 1'b1;
    cpu_req = 1'b0;
    vq.delete();
    cq.delete();
    wq.delete();
    #1;
    chk_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_noack", ack_cnt - base, 0);
    cpu_access(1'b0, 13'h0010, 8'h00, 4);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
